// File: rtl/bitstream_eval_ctrl.sv
// Sequences one stochastic evaluation epoch: clear the constant generators, skip the
// pipeline warm-up, count ones in the network output over 2^LEN_LOG2 cycles, report.
module bitstream_eval_ctrl #(
    parameter int unsigned LEN_LOG2 = 12,
    parameter int unsigned WARMUP   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                bit_in,
    output logic                busy,
    output logic                gen_clr,
    output logic                gen_en,
    output logic [LEN_LOG2-1:0] bit_idx,
    output logic [LEN_LOG2:0]   count,
    output logic                count_valid,
    output logic                done
);

    typedef enum logic [2:0] {StIdle, StClear, StWarm, StRun, StDone} state_e;

    localparam logic [LEN_LOG2-1:0] SampleLast = {LEN_LOG2{1'b1}};
    localparam logic [LEN_LOG2-1:0] WarmLast   = LEN_LOG2'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [LEN_LOG2-1:0] IdxOne     = LEN_LOG2'(1);

    state_e              state_q, state_d;
    logic [LEN_LOG2-1:0] cnt_q, cnt_d;
    logic [LEN_LOG2-1:0] bit_idx_q, bit_idx_d;
    logic [LEN_LOG2:0]   acc_q, acc_d;
    logic [LEN_LOG2:0]   count_q, count_d;
    logic                count_valid_q, count_valid_d;
    logic                busy_q, busy_d;
    logic                gen_clr_q, gen_clr_d;
    logic                gen_en_q, gen_en_d;
    logic                done_q, done_d;
    logic [LEN_LOG2:0]   acc_inc;

    assign acc_inc = acc_q + {{LEN_LOG2{1'b0}}, bit_in};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        acc_d         = acc_q;
        count_d       = count_q;
        count_valid_d = count_valid_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d       = StClear;
                    cnt_d         = '0;
                    bit_idx_d     = '0;
                    acc_d         = '0;
                    count_valid_d = 1'b0;
                end
            end
            StClear: begin
                state_d = (WARMUP > 0) ? StWarm : StRun;
            end
            StWarm: begin
                bit_idx_d = bit_idx_q + IdxOne;
                cnt_d     = cnt_q + IdxOne;
                if (cnt_q == WarmLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                bit_idx_d = bit_idx_q + IdxOne;
                cnt_d     = cnt_q + IdxOne;
                acc_d     = acc_inc;
                if (cnt_q == SampleLast) begin
                    state_d       = StDone;
                    count_d       = acc_inc;
                    count_valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins even on the last RUN sample: no result is published.
        if (abort && (state_q == StClear || state_q == StWarm || state_q == StRun)) begin
            state_d       = StIdle;
            count_d       = count_q;
            count_valid_d = 1'b0;
        end

        busy_d    = (state_d == StClear) || (state_d == StWarm) || (state_d == StRun);
        gen_clr_d = (state_d == StClear);
        gen_en_d  = (state_d == StWarm) || (state_d == StRun);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            acc_q         <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            gen_clr_q     <= 1'b0;
            gen_en_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            busy_q        <= busy_d;
            gen_clr_q     <= gen_clr_d;
            gen_en_q      <= gen_en_d;
            done_q        <= done_d;
        end
    end

    assign busy        = busy_q;
    assign gen_clr     = gen_clr_q;
    assign gen_en      = gen_en_q;
    assign bit_idx     = bit_idx_q;
    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_bitstream_eval_ctrl.sv
// Directed bench for bitstream_eval_ctrl with LEN_LOG2=4 (N=16) and WARMUP=2.
module tb_bitstream_eval_ctrl;

    localparam int unsigned LEN_LOG2 = 4;
    localparam int unsigned WARMUP   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic                bit_in;
    logic                busy;
    logic                gen_clr;
    logic                gen_en;
    logic [LEN_LOG2-1:0] bit_idx;
    logic [LEN_LOG2:0]   count;
    logic                count_valid;
    logic                done;

    int n_checks = 0;
    int n_errors = 0;

    bitstream_eval_ctrl #(
        .LEN_LOG2(LEN_LOG2),
        .WARMUP  (WARMUP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .bit_in     (bit_in),
        .busy       (busy),
        .gen_clr    (gen_clr),
        .gen_en     (gen_en),
        .bit_idx    (bit_idx),
        .count      (count),
        .count_valid(count_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    // {busy, gen_clr, gen_en, bit_idx[3:0], count[4:0], count_valid, done}
    logic [13:0] obs;
    assign obs = {busy, gen_clr, gen_en, bit_idx, count, count_valid, done};

    typedef struct packed {
        logic        start;
        logic        abort;
        logic        bit_in;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl [22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one epoch from IDLE. mode 0: ones only in WARM; 1: alternating 1/0 in RUN;
    // 2: all ones. Checks done latency, count and count_valid.
    task automatic run_epoch(input int mode, input logic [4:0] exp_count);
        int found;
        found = -1;
        start = 1'b1;
        abort = 1'b0;
        bit_in = 1'b0;
        step();
        start = 1'b0;
        check("clear_cv_low", {31'd0, count_valid}, 32'd0);
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                found = k;
                break;
            end
            if (k == 2 || k == 3) bit_in = (mode != 1);
            else if (k >= 4 && k <= 19) begin
                case (mode)
                    0:       bit_in = 1'b0;
                    1:       bit_in = ((k - 4) % 2 == 0);
                    default: bit_in = 1'b1;
                endcase
            end else bit_in = 1'b0;
            step();
        end
        check("epoch_done_latency", found, 32'd20);
        check("epoch_count", {27'd0, count}, {27'd0, exp_count});
        check("epoch_count_valid", {31'd0, count_valid}, 32'd1);
        bit_in = 1'b0;
        step();
    endtask

    initial begin
        int          done_q[$];
        int          clr_q[$];
        int          exp_done[3];
        int          exp_clr[3];
        int          n_done;
        int          n_clr;
        int          lat;

        exp_done = '{20, 41, 62};
        exp_clr  = '{1, 22, 43};

        // Timeline of the first all-ones epoch, start pulsed at cycle 0.
        for (int c = 0; c < 22; c++) begin
            tbl[c]        = '0;
            tbl[c].bit_in = 1'b1;
            if (c == 0) tbl[c].start = 1'b1;
            if (c == 1) tbl[c].exp = {1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
            else if (c >= 2 && c <= 19)
                tbl[c].exp = {1'b1, 1'b0, 1'b1, 4'(c - 2), 5'd0, 1'b0, 1'b0};
            else if (c == 20) tbl[c].exp = {1'b0, 1'b0, 1'b0, 4'd2, 5'd16, 1'b1, 1'b1};
            else if (c == 21) tbl[c].exp = {1'b0, 1'b0, 1'b0, 4'd2, 5'd16, 1'b1, 1'b0};
        end

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bit_in = 1'b0;
        step();
        step();
        rst = 1'b0;

        for (int c = 0; c < 22; c++) begin
            start  = tbl[c].start;
            abort  = tbl[c].abort;
            bit_in = tbl[c].bit_in;
            check($sformatf("timeline_c%0d", c), {18'd0, obs}, {18'd0, tbl[c].exp});
            step();
        end
        start = 1'b0;

        run_epoch(0, 5'd0);
        run_epoch(1, 5'd8);

        // Abort at RUN sample 5 (cycle 9 after start).
        start = 1'b1;
        bit_in = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 9; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_gen_en", {31'd0, gen_en}, 32'd0);
        check("abort_cv", {31'd0, count_valid}, 32'd0);
        check("abort_count_kept", {27'd0, count}, 32'd8);
        n_done = 0;
        for (int k = 0; k < 25; k++) begin
            if (done || busy) n_done++;
            step();
        end
        check("abort_no_done", n_done, 32'd0);

        // start held for 60 cycles: epochs every 21 cycles.
        start = 1'b1;
        bit_in = 1'b1;
        for (int c = 0; c < 66; c++) begin
            if (c == 60) start = 1'b0;
            if (done) done_q.push_back(c);
            if (gen_clr) begin
                clr_q.push_back(c);
                check("held_clear_cv", {31'd0, count_valid}, 32'd0);
            end
            step();
        end
        start = 1'b0;
        check("held_n_done", done_q.size(), 32'd3);
        check("held_n_clr", clr_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < done_q.size()) check("held_done_cycle", done_q[i], exp_done[i]);
            if (i < clr_q.size()) check("held_clr_cycle", clr_q[i], exp_clr[i]);
        end

        // Reset during WARM.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_in_warm_outs", {18'd0, obs}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            step();
        end
        check("post_rst_latency", lat, 32'd20);
        check("post_rst_count", {27'd0, count}, 32'd16);
        step();

        // start pulsed during RUN is ignored.
        start = 1'b1;
        step();
        n_done = 0;
        n_clr = 1;
        for (int k = 1; k <= 50; k++) begin
            start = (k == 10);
            if (done) n_done++;
            if (gen_clr && k > 1) n_clr++;
            step();
        end
        start = 1'b0;
        check("run_start_one_done", n_done, 32'd1);
        check("run_start_one_clear", n_clr, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bitstream_eval_ctrl.md
Name: bitstream_eval_ctrl

Overview:
Sequencer for one stochastic evaluation epoch of the bitstream network. It restarts the shared bitstream constant generators with a synchronous clear pulse and drives their stream index and enable. It discards the network pipeline warm-up cycles, then counts the ones in the network output stream over exactly 2^LEN_LOG2 cycles. It reports the decoded count with a start/busy/done handshake.

Parameters:
LEN_LOG2, 12, log2 of the stream length N (N = 4096 by default); LEN_LOG2 >= 2.
WARMUP, 2, number of cycles after the clear cycle during which bit_in is ignored; range 0..N-1.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous reset, active-high.
start  in  1  request an epoch; sampled only in IDLE.
abort  in  1  cancel the active epoch; has priority over start.
bit_in  in  1  network output bitstream.
busy  out  1  high in CLEAR, WARM and RUN.
gen_clr  out  1  one-cycle pulse in CLEAR; restarts the generators at their offsets.
gen_en  out  1  high in WARM and RUN; advances the generators.
bit_idx  out  LEN_LOG2  current stream index; drives the shared constant-stream address.
count  out  LEN_LOG2+1  number of ones sampled in RUN.
count_valid  out  1  count is a completed result.
done  out  1  one-cycle pulse on epoch completion.

Behaviour:
- Reset (sync, rst=1 at a posedge): state becomes IDLE; busy, gen_clr, gen_en, bit_idx, count, count_valid and done are all 0. rst overrides every other input.
- States: IDLE, CLEAR, WARM, RUN, DONE.
- IDLE: start=1 and abort=0 -> CLEAR. Otherwise stay in IDLE.
- CLEAR (1 cycle): gen_clr=1, gen_en=0. bit_idx, the internal accumulator and the sample counter are cleared. count_valid is cleared. Next state is WARM if WARMUP>0, else RUN.
- WARM (WARMUP cycles): gen_en=1. bit_in is ignored. After the last warm cycle -> RUN.
- RUN (exactly N cycles): gen_en=1. Each cycle acc += bit_in. The sample counter runs 0..N-1; on sample N-1 -> DONE.
- DONE (1 cycle): done=1, busy=0, gen_en=0, count_valid=1. count holds the total including the last RUN sample; count is loaded on the edge that enters DONE. Next state is IDLE.
- bit_idx increments mod N on every cycle that gen_en=1, otherwise holds. At DONE, bit_idx = WARMUP mod N.
- count width LEN_LOG2+1: an all-ones stream gives exactly N, so no saturation or wrap is needed. count and count_valid hold until the next CLEAR.
- Latency: start sampled in IDLE at cycle t -> CLEAR at t+1 -> RUN starts at t+2+WARMUP -> done at t+2+WARMUP+N.
- Back-to-back: DONE always passes through IDLE. With start held high, epochs repeat every WARMUP+N+3 cycles.
- abort=1 in CLEAR, WARM or RUN -> IDLE on the next cycle. There is no done pulse, count_valid stays 0 and gen_en drops to 0. count keeps the last completed value.
- abort in IDLE or DONE has no effect. DONE still pulses done and returns to IDLE.
- start and abort both high in IDLE -> stay in IDLE. start outside IDLE is ignored and is not queued.

Test Plan:
- LEN_LOG2=4, WARMUP=2, bit_in=1 constant, start pulse at cycle 0 -> gen_clr=1 at cycle 1 only; gen_en=1 over cycles 2..19; done=1 at cycle 20 only; count=16, count_valid=1, bit_idx=2 at cycle 20.
- Same config, bit_in=1 only during WARM cycles and 0 during RUN -> count=0. bit_in alternating 1/0 during RUN -> count=8.
- abort=1 at RUN sample 5 -> IDLE on the next cycle; busy=0, gen_en=0; no done pulse; count_valid=0; count unchanged from the previous epoch.
- start held high for 60 cycles -> done at cycles 20, 41 and 62 (period 21). gen_clr pulses at cycles 1, 22 and 43. count_valid drops at each CLEAR.
- rst=1 during WARM -> on the next cycle every output is 0 and state is IDLE. A following start gives nominal timing (done at start cycle + 20).
- start pulsed during RUN is ignored: a single done pulse, with no second epoch following.
